// File: rtl/mccu_multicycle.sv
`default_nettype none
// ============================================================================
// mccu_multicycle : IF/ID/EXE/MEM/WB sequencer for the single-memory MIPS core
// Revision 1.0
// ============================================================================
module mccu_multicycle (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       z,
   input  logic       mem_rdy,
   output logic       mem_req,
   output logic       iord,
   output logic       wmem,
   output logic       wir,
   output logic       wpc,
   output logic       wreg,
   output logic       regrt,
   output logic       m2reg,
   output logic       jal,
   output logic       shift,
   output logic       sext,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [3:0] aluc,
   output logic [1:0] pcsource,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_SRL = 6'b000010;
   localparam logic [5:0] F_SRA = 6'b000011;
   localparam logic [5:0] F_JR  = 6'b001000;
   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_XOR = 6'b100110;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_AND = 4'b0001;
   localparam logic [3:0] ALU_XOR = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0011;
   localparam logic [3:0] ALU_SUB = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_LUI = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1111;

   state_e state_q, state_d;

   logic       is_r_alu, is_shift, is_jr, is_itype, is_addi;
   logic       is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_nop;
   logic [3:0] aluc_r, aluc_i;

   // Instruction-class decode; anything not recognised here falls out as a NOP.
   always_comb begin
      is_r_alu = 1'b0;
      is_shift = 1'b0;
      is_jr    = 1'b0;
      aluc_r   = ALU_ADD;
      if (op == OP_RTYPE) begin
         case (func)
            F_ADD:   begin is_r_alu = 1'b1; aluc_r = ALU_ADD; end
            F_SUB:   begin is_r_alu = 1'b1; aluc_r = ALU_SUB; end
            F_AND:   begin is_r_alu = 1'b1; aluc_r = ALU_AND; end
            F_OR:    begin is_r_alu = 1'b1; aluc_r = ALU_OR;  end
            F_XOR:   begin is_r_alu = 1'b1; aluc_r = ALU_XOR; end
            F_SLL:   begin is_r_alu = 1'b1; is_shift = 1'b1; aluc_r = ALU_SLL; end
            F_SRL:   begin is_r_alu = 1'b1; is_shift = 1'b1; aluc_r = ALU_SRL; end
            F_SRA:   begin is_r_alu = 1'b1; is_shift = 1'b1; aluc_r = ALU_SRA; end
            F_JR:    is_jr = 1'b1;
            default: ;
         endcase
      end

      is_itype = 1'b1;
      aluc_i   = ALU_ADD;
      case (op)
         OP_ADDI: aluc_i = ALU_ADD;
         OP_ANDI: aluc_i = ALU_AND;
         OP_ORI:  aluc_i = ALU_OR;
         OP_XORI: aluc_i = ALU_XOR;
         OP_LUI:  aluc_i = ALU_LUI;
         default: is_itype = 1'b0;
      endcase

      is_addi = (op == OP_ADDI);
      is_lw   = (op == OP_LW);
      is_sw   = (op == OP_SW);
      is_beq  = (op == OP_BEQ);
      is_bne  = (op == OP_BNE);
      is_j    = (op == OP_J);
      is_jal  = (op == OP_JAL);
      is_nop  = !(is_r_alu || is_jr || is_itype || is_lw || is_sw ||
                  is_beq || is_bne || is_j || is_jal);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IF;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      iord     = 1'b0;
      wmem     = 1'b0;
      wir      = 1'b0;
      wpc      = 1'b0;
      wreg     = 1'b0;
      regrt    = 1'b0;
      m2reg    = 1'b0;
      jal      = 1'b0;
      shift    = 1'b0;
      sext     = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      aluc     = ALU_ADD;
      pcsource = 2'b00;

      case (state_q)
         S_IF: begin
            mem_req = 1'b1;
            alusrcb = 2'b01;
            if (mem_rdy) begin
               wir     = 1'b1;
               wpc     = 1'b1;
               state_d = S_ID;
            end
         end
         S_ID: begin
            // ALU computes PC+4 + (imm<<2) into the target register meanwhile
            alusrcb = 2'b11;
            sext    = 1'b1;
            if (is_j || is_jal) begin
               wpc      = 1'b1;
               pcsource = 2'b11;
               wreg     = is_jal;
               jal      = is_jal;
               state_d  = S_IF;
            end else if (is_jr) begin
               wpc      = 1'b1;
               pcsource = 2'b10;
               state_d  = S_IF;
            end else if (is_nop) begin
               state_d  = S_IF;
            end else begin
               state_d  = S_EXE;
            end
         end
         S_EXE: begin
            state_d = S_IF;
            if (is_r_alu) begin
               alusrca = 1'b1;
               shift   = is_shift;
               aluc    = aluc_r;
               state_d = S_WB;
            end else if (is_itype) begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
               sext    = is_addi;
               aluc    = aluc_i;
               state_d = S_WB;
            end else if (is_lw || is_sw) begin
               alusrca = 1'b1;
               alusrcb = 2'b10;
               sext    = 1'b1;
               state_d = S_MEM;
            end else if (is_beq || is_bne) begin
               alusrca = 1'b1;
               aluc    = ALU_SUB;
               if ((is_beq && z) || (is_bne && !z)) begin
                  wpc      = 1'b1;
                  pcsource = 2'b01;
               end
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            wmem    = is_sw;
            if (mem_rdy) state_d = is_lw ? S_WB : S_IF;
         end
         S_WB: begin
            wreg    = 1'b1;
            regrt   = is_itype || is_lw;
            m2reg   = is_lw;
            state_d = S_IF;
         end
         default: state_d = S_IF;
      endcase

      // Reset aborts whatever is in flight: no enables, no selects.
      if (rst) begin
         state_d  = S_IF;
         mem_req  = 1'b0;
         iord     = 1'b0;
         wmem     = 1'b0;
         wir      = 1'b0;
         wpc      = 1'b0;
         wreg     = 1'b0;
         regrt    = 1'b0;
         m2reg    = 1'b0;
         jal      = 1'b0;
         shift    = 1'b0;
         sext     = 1'b0;
         alusrca  = 1'b0;
         alusrcb  = 2'b00;
         aluc     = ALU_ADD;
         pcsource = 2'b00;
      end
   end

   assign state = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mccu_multicycle.sv
`default_nettype none
// ============================================================================
// tb_mccu_multicycle : scoreboard bench for the multicycle control unit
// Revision 1.0
// ============================================================================
module tb_mccu_multicycle;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op, func;
   logic       z, mem_rdy;
   logic       mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal, shift, sext, alusrca;
   logic [1:0] alusrcb, pcsource;
   logic [3:0] aluc;
   logic [2:0] state;

   typedef struct packed {
      logic [2:0] st;
      logic mreq, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal, shift, sext, asa;
      logic [1:0] asb;
      logic [3:0] aluc;
      logic [1:0] pcs;
   } out_t;

   typedef struct packed {
      logic       rst;
      logic [5:0] op;
      logic [5:0] func;
      logic       z;
      logic       rdy;
   } stim_t;

   out_t  obs;
   stim_t stim_q[$];
   out_t  exp_q[$];
   int    total = 0;
   int    bad   = 0;

   mccu_multicycle dut (
      .clk(clk), .rst(rst), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
      .mem_req(mem_req), .iord(iord), .wmem(wmem), .wir(wir), .wpc(wpc),
      .wreg(wreg), .regrt(regrt), .m2reg(m2reg), .jal(jal), .shift(shift),
      .sext(sext), .alusrca(alusrca), .alusrcb(alusrcb), .aluc(aluc),
      .pcsource(pcsource), .state(state)
   );

   always #5 clk = ~clk;

   assign obs = {state, mem_req, iord, wmem, wir, wpc, wreg, regrt, m2reg, jal,
                 shift, sext, alusrca, alusrcb, aluc, pcsource};

   function automatic stim_t mk(input logic r, input logic [5:0] o, input logic [5:0] f,
                                input logic zz, input logic rdy);
      stim_t s;
      s.rst = r; s.op = o; s.func = f; s.z = zz; s.rdy = rdy;
      return s;
   endfunction

   function automatic out_t e_if(input logic rdy);
      out_t e = '0;
      e.mreq = 1'b1; e.asb = 2'b01; e.wir = rdy; e.wpc = rdy;
      return e;
   endfunction

   function automatic out_t e_id();
      out_t e = '0;
      e.st = 3'd1; e.asb = 2'b11; e.sext = 1'b1;
      return e;
   endfunction

   task automatic push(input stim_t s, input out_t e);
      stim_q.push_back(s);
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      stim_t s; out_t e; int n = 0;
      push(mk(1, 6'h00, 6'h20, 0, 1), '0);
      push(mk(1, 6'h00, 6'h20, 0, 1), '0);
      push(mk(0, 6'h00, 6'h20, 0, 0), e_if(0));
      push(mk(0, 6'h00, 6'h20, 0, 0), e_if(0));
      while (stim_q.size() != 0) begin
         s = stim_q.pop_front();
         rst = s.rst; op = s.op; func = s.func; z = s.z; mem_rdy = s.rdy;
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL reset[%0d]: got=%h want=%h", n, obs, e);
         end
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_rtype();
      stim_t s; out_t e; int n = 0;
      logic [5:0] fn[5] = '{6'b100000, 6'b100010, 6'b000000, 6'b000011, 6'b100101};
      logic [3:0] ac[5] = '{4'b0000, 4'b0100, 4'b0011, 4'b1111, 4'b0101};
      logic       sh[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) begin
         push(mk(0, 6'h00, fn[i], 0, 1), e_if(1));
         push(mk(0, 6'h00, fn[i], 0, 1), e_id());
         e = '0; e.st = 3'd2; e.asa = 1'b1; e.aluc = ac[i]; e.shift = sh[i];
         push(mk(0, 6'h00, fn[i], 0, 1), e);
         e = '0; e.st = 3'd4; e.wreg = 1'b1;
         push(mk(0, 6'h00, fn[i], 0, 1), e);
      end
      while (stim_q.size() != 0) begin
         s = stim_q.pop_front();
         rst = s.rst; op = s.op; func = s.func; z = s.z; mem_rdy = s.rdy;
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL rtype[%0d]: got=%h want=%h", n, obs, e);
         end
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_itype();
      stim_t s; out_t e; int n = 0;
      logic [5:0] oc[4] = '{6'b001000, 6'b001101, 6'b001111, 6'b001110};
      logic [3:0] ac[4] = '{4'b0000, 4'b0101, 4'b0110, 4'b0010};
      logic       sx[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         push(mk(0, oc[i], 6'h3f, 0, 1), e_if(1));
         push(mk(0, oc[i], 6'h3f, 0, 1), e_id());
         e = '0; e.st = 3'd2; e.asa = 1'b1; e.asb = 2'b10; e.aluc = ac[i]; e.sext = sx[i];
         push(mk(0, oc[i], 6'h3f, 0, 1), e);
         e = '0; e.st = 3'd4; e.wreg = 1'b1; e.regrt = 1'b1;
         push(mk(0, oc[i], 6'h3f, 0, 1), e);
      end
      while (stim_q.size() != 0) begin
         s = stim_q.pop_front();
         rst = s.rst; op = s.op; func = s.func; z = s.z; mem_rdy = s.rdy;
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL itype[%0d]: got=%h want=%h", n, obs, e);
         end
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_lw_wait();
      stim_t s; out_t e, em; int n = 0;
      push(mk(0, 6'b100011, 6'h00, 0, 0), e_if(0));
      push(mk(0, 6'b100011, 6'h00, 0, 1), e_if(1));
      push(mk(0, 6'b100011, 6'h00, 0, 0), e_id());
      e = '0; e.st = 3'd2; e.asa = 1'b1; e.asb = 2'b10; e.sext = 1'b1;
      push(mk(0, 6'b100011, 6'h00, 0, 0), e);
      em = '0; em.st = 3'd3; em.mreq = 1'b1; em.iord = 1'b1;
      push(mk(0, 6'b100011, 6'h00, 0, 0), em);
      push(mk(0, 6'b100011, 6'h00, 0, 0), em);
      push(mk(0, 6'b100011, 6'h00, 0, 1), em);
      e = '0; e.st = 3'd4; e.wreg = 1'b1; e.regrt = 1'b1; e.m2reg = 1'b1;
      push(mk(0, 6'b100011, 6'h00, 0, 0), e);
      push(mk(0, 6'b100011, 6'h00, 0, 0), e_if(0));
      while (stim_q.size() != 0) begin
         s = stim_q.pop_front();
         rst = s.rst; op = s.op; func = s.func; z = s.z; mem_rdy = s.rdy;
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL lw[%0d]: got=%h want=%h", n, obs, e);
         end
         @(posedge clk); #1;
         if (n == 8) mem_rdy = 1'b1;
         n++;
      end
      // leave IF cleanly for the next test
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
   endtask

   task automatic test_branch();
      stim_t s; out_t e; int n = 0;
      logic [5:0] oc[4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
      logic       zz[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic       tk[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         push(mk(0, oc[i], 6'h20, zz[i], 1), e_if(1));
         push(mk(0, oc[i], 6'h20, zz[i], 1), e_id());
         e = '0; e.st = 3'd2; e.asa = 1'b1; e.aluc = 4'b0100;
         e.wpc = tk[i]; e.pcs = tk[i] ? 2'b01 : 2'b00;
         push(mk(0, oc[i], 6'h20, zz[i], 1), e);
      end
      while (stim_q.size() != 0) begin
         s = stim_q.pop_front();
         rst = s.rst; op = s.op; func = s.func; z = s.z; mem_rdy = s.rdy;
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL branch[%0d]: got=%h want=%h", n, obs, e);
         end
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_jumps_nop();
      stim_t s; out_t e; int n = 0;
      push(mk(0, 6'b000011, 6'h00, 0, 1), e_if(1));
      e = e_id(); e.wpc = 1'b1; e.pcs = 2'b11; e.wreg = 1'b1; e.jal = 1'b1;
      push(mk(0, 6'b000011, 6'h00, 0, 1), e);
      push(mk(0, 6'b111111, 6'h00, 0, 1), e_if(1));
      push(mk(0, 6'b111111, 6'h00, 0, 1), e_id());
      push(mk(0, 6'b000010, 6'h00, 0, 1), e_if(1));
      e = e_id(); e.wpc = 1'b1; e.pcs = 2'b11;
      push(mk(0, 6'b000010, 6'h00, 0, 1), e);
      push(mk(0, 6'b000000, 6'b001000, 0, 1), e_if(1));
      e = e_id(); e.wpc = 1'b1; e.pcs = 2'b10;
      push(mk(0, 6'b000000, 6'b001000, 0, 1), e);
      push(mk(0, 6'b000000, 6'b111111, 0, 1), e_if(1));
      push(mk(0, 6'b000000, 6'b111111, 0, 1), e_id());
      push(mk(0, 6'b000000, 6'b111111, 0, 0), e_if(0));
      while (stim_q.size() != 0) begin
         s = stim_q.pop_front();
         rst = s.rst; op = s.op; func = s.func; z = s.z; mem_rdy = s.rdy;
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL jump[%0d]: got=%h want=%h", n, obs, e);
         end
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic test_sw_reset();
      stim_t s; out_t e, ex, em; int n = 0;
      ex = '0; ex.st = 3'd2; ex.asa = 1'b1; ex.asb = 2'b10; ex.sext = 1'b1;
      em = '0; em.st = 3'd3; em.mreq = 1'b1; em.iord = 1'b1; em.wmem = 1'b1;
      // plain store: MEM completes at once and returns to IF
      push(mk(0, 6'b101011, 6'h00, 0, 1), e_if(1));
      push(mk(0, 6'b101011, 6'h00, 0, 1), e_id());
      push(mk(0, 6'b101011, 6'h00, 0, 1), ex);
      push(mk(0, 6'b101011, 6'h00, 0, 1), em);
      // store aborted by reset while memory is stalled
      push(mk(0, 6'b101011, 6'h00, 0, 1), e_if(1));
      push(mk(0, 6'b101011, 6'h00, 0, 1), e_id());
      push(mk(0, 6'b101011, 6'h00, 0, 1), ex);
      push(mk(0, 6'b101011, 6'h00, 0, 0), em);
      e = '0; e.st = 3'd3;
      push(mk(1, 6'b101011, 6'h00, 0, 0), e);
      push(mk(0, 6'b101011, 6'h00, 0, 1), e_if(1));
      push(mk(0, 6'b111111, 6'h00, 0, 1), e_id());
      push(mk(0, 6'b111111, 6'h00, 0, 0), e_if(0));
      while (stim_q.size() != 0) begin
         s = stim_q.pop_front();
         rst = s.rst; op = s.op; func = s.func; z = s.z; mem_rdy = s.rdy;
         @(negedge clk);
         e = exp_q.pop_front();
         total++;
         if (obs !== e) begin
            bad++;
            $display("FAIL sw[%0d]: got=%h want=%h", n, obs, e);
         end
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      rst = 1'b1; op = '0; func = '0; z = 1'b0; mem_rdy = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_rtype();
      test_itype();
      test_lw_wait();
      test_branch();
      test_jumps_nop();
      test_sw_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
